// File: rtl/lsu_req_ctrl.sv
// Load/store request controller: single outstanding access toward a word-wide data memory.
// Optional define LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module lsu_req_ctrl #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              stall,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wr,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   state_e              state_q;
   logic                we_q;
   logic [2:0]          funct3_q;
   logic [1:0]          lane_q;
   logic                err_q;
   logic [CntW-1:0]     cnt_q;
   logic                resp_valid_q;
   logic                resp_err_q;
   logic [DATA_W-1:0]   resp_rdata_q;
   logic [31:0]         mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [3:0]          mem_wr_q;

   logic                req_illegal;
   logic                req_misal;
   logic                req_err;
   logic [3:0]          req_wr_en;
   logic [DATA_W-1:0]   req_wdata_rep;

   // Decode of the incoming request, consumed only at the handshake edge.
   always_comb begin
      req_illegal   = 1'b0;
      req_wr_en     = 4'b0000;
      req_wdata_rep = req_wdata;
      if (req_we) begin
         case (req_funct3)
            3'b000: begin
               req_wr_en     = 4'b0001 << req_addr[1:0];
               req_wdata_rep = {4{req_wdata[7:0]}};
            end
            3'b001: begin
               req_wr_en     = req_addr[1] ? 4'b1100 : 4'b0011;
               req_wdata_rep = {2{req_wdata[15:0]}};
            end
            3'b010:  req_wr_en   = 4'b1111;
            default: req_illegal = 1'b1;
         endcase
      end else begin
         case (req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_illegal = 1'b0;
            default:                                req_illegal = 1'b1;
         endcase
      end
      req_err = req_illegal | req_misal;
      if (req_err || !req_we) begin
         req_wr_en = 4'b0000;
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
   assign req_misal = 1'b0;
`endif

   function automatic logic [31:0] load_extract(input logic [2:0]  funct3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (funct3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'h000000, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'h0000, h};
         default: return word;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         lane_q       <= 2'b00;
         err_q        <= 1'b0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wr_q     <= 4'b0000;
      end else begin
         case (state_q)
            StIdle: begin
               resp_valid_q <= 1'b0;
               if (req_valid) begin
                  state_q     <= StIssue;
                  we_q        <= req_we;
                  funct3_q    <= req_funct3;
                  lane_q      <= req_addr[1:0];
                  err_q       <= req_err;
                  mem_addr_q  <= 32'(req_addr) & ~32'h3;
                  mem_wr_q    <= req_wr_en;
                  mem_wdata_q <= req_we ? req_wdata_rep : '0;
               end
            end
            StIssue: begin
               mem_wr_q <= 4'b0000;
               if (err_q || we_q) begin
                  state_q      <= StDone;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= err_q;
                  resp_rdata_q <= '0;
                  mem_addr_q   <= '0;
               end else begin
                  state_q <= StWait;
                  cnt_q   <= CntW'(RD_LAT - 1);
               end
            end
            StWait: begin
               if (cnt_q == '0) begin
                  state_q      <= StDone;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= load_extract(funct3_q, lane_q, mem_rdata);
                  mem_addr_q   <= '0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q      <= StIdle;
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= '0;
               mem_wdata_q  <= '0;
            end
         endcase
      end
   end

   assign req_ready  = (state_q == StIdle) && !reset;
   assign stall      = (state_q == StIdle) ? req_valid :
                       ((state_q == StIssue) || (state_q == StWait));
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wr     = mem_wr_q;

endmodule

// File: doc/lsu_req_ctrl.md
# lsu_req_ctrl

Load/store initiator between the MEM pipeline stage and the word-wide data memory. Accepts one load or store per handshake, drives the memory port with a word address, byte write-enables and lane-replicated write data, and waits a fixed read latency. It returns the aligned, sign- or zero-extended load result and raises `stall` toward the pipeline while an access is in flight.

## Interface
- `ADDR_W`, default 9: byte-address width from the ALU.
- `DATA_W`, default 32: data width. Only 32 is supported.
- `RD_LAT`, default 1: memory read latency in cycles. Must be ≥1.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  access request.
- `req_ready`  out  1  request accepted when both `req_valid` and `req_ready` are high.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  instruction bits 14:12.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data (rs2).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result. 0 for stores and errors.
- `resp_err`  out  1  error flag, valid with `resp_valid`.
- `stall`  out  1  pipeline hold.
- `mem_addr`  out  32  word-aligned address, zero-extended, bits [1:0] = 0.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_wr`  out  4  byte write enables. Bit i enables byte lane i.
- `mem_rdata`  in  32  memory read word.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE → ISSUE on handshake. The request is registered at that edge.
- ISSUE → WAIT for a legal load. ISSUE → DONE for a store or an error.
- WAIT runs a counter from `RD_LAT`-1 down to 0. It moves to DONE when the count is 0 and captures `mem_rdata` at that edge.
- DONE → IDLE unconditionally.
- `req_ready` = (state==IDLE) and not `reset`.
- `mem_addr` is held from ISSUE through the end of WAIT. It is 0 in IDLE.
- `mem_wr` is nonzero only in ISSUE, and only for a legal store.
- Store encoding (lane = addr[1:0]):
  - SB (000): `mem_wr` = 1<<lane; `mem_wdata` = byte replicated ×4.
  - SH (001): `mem_wr` = addr[1] ? 1100 : 0011; `mem_wdata` = halfword replicated ×2.
  - SW (010): `mem_wr` = 1111.
  - Any other funct3 sets `resp_err`.
- Load encoding:
  - LB (000) / LBU (100): select the byte by lane; sign- or zero-extend.
  - LH (001) / LHU (101): select the halfword by addr[1]; sign- or zero-extend.
  - LW (010): the full word.
  - Any other funct3 sets `resp_err`.
- `stall` = `req_valid` in IDLE; 1 in ISSUE and WAIT; 0 in DONE, so the pipeline advances with the result.
- Reset values: state IDLE, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, counter 0.
- Reset mid-operation, in any state: the FSM is in IDLE at the next edge. No `resp_valid` is produced and no further `mem_wr` is asserted.

## Timing
- The handshake is in cycle 0.
- ISSUE is cycle 1.
- Store: `resp_valid` in cycle 2.
- Load: `mem_rdata` is sampled at the end of cycle `RD_LAT`+1, and `resp_valid` is in cycle `RD_LAT`+2.
- Back-to-back requests: the next handshake can occur at the earliest in the cycle after DONE, which gives a throughput of one access per 3 cycles (stores) or `RD_LAT`+3 cycles (loads).
- `req_valid` asserted during reset is not accepted.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - The following accesses are misaligned: LH, LHU or SH with addr[0]=1; LW or SW with addr[1:0]≠0.
  - A misaligned access suppresses `mem_wr`, skips WAIT and completes with `resp_err`=1 and `resp_rdata`=0.
- Undefined:
  - Offending low bits are ignored: halfwords use addr[1] only, and words use the aligned word.
  - `resp_err` is raised only for an illegal funct3.

## Test plan
- SB, addr 0x006, wdata 0x000000AB → in cycle 1: `mem_addr`=0x004, `mem_wr`=0100, `mem_wdata`=0xABABABAB. `resp_valid` in cycle 2 with `resp_err`=0.
- `mem_rdata`=0x80FF1234:
  - LB at addr 0x003 → `resp_rdata`=0xFFFFFF80.
  - LBU at addr 0x003 → 0x00000080.
  - LHU at addr 0x002 → 0x000080FF.
  - LW at addr 0x000 → 0x80FF1234.
- `RD_LAT`=3, LW at addr 0x010 → `stall` high in cycles 0–4, `resp_valid` in cycle 5, `mem_addr` = 0x010 throughout cycles 1–4.
- LW at addr 0x002:
  - With `LSU_MISALIGN_TRAP_EN` → `resp_valid` in cycle 2 with `resp_err`=1, `resp_rdata`=0.
  - Without it → word 0x000 is returned and `resp_err`=0.
- SH at addr 0x001 with macro → `mem_wr` stays 0000 in all cycles.
- Store with funct3=011 → `resp_err`=1 and `mem_wr`=0000.
- `reset` pulsed during WAIT of a load with `RD_LAT`=3 → IDLE next cycle, `req_ready`=1, and no `resp_valid` pulse follows.
- `req_valid` held high for two stores → the second handshake occurs in cycle 3 and gives exactly two `mem_wr` pulses.
